bus_interconnect: RTL and testbench

BUS_INTERCONNECT -- requirements
Module: bus_interconnect

---
 rtl/bus_interconnect.sv | 97 +++++++++
 tb/tb_bus_interconnect.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_interconnect.sv
// bus_interconnect: single-master address decoder with wait-state timeout,
// one-cycle error response and sticky error capture.
module bus_interconnect #(
  parameter int                        NUM_SLAVES     = 9,
  parameter logic [NUM_SLAVES*32-1:0]  SLV_BASE       = '0,
  parameter logic [NUM_SLAVES*32-1:0]  SLV_MASK       = '0,
  parameter int                        TIMEOUT_CYCLES = 255,
  parameter logic [31:0]               ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     m_valid,
  input  logic [31:0]              m_addr,
  input  logic [3:0]               m_wstrb,
  output logic                     m_ready,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_sel,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  output logic                     err_irq,
  output logic [31:0]              err_addr,
  output logic                     err_write,
  output logic [7:0]               err_count,
  input  logic                     err_clr
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic hit, sel_ready, err_entry;
  logic [NUM_SLAVES-1:0] win;
  logic [31:0] win_rdata;
  // first matching index claims the hit, so lower indices take priority
  always_comb begin
    hit = 1'b0;
    win = '0;
    win_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (!hit && (m_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit = 1'b1;
        win[i] = 1'b1;
        win_rdata = s_rdata[32*i +: 32];
      end
  end
  assign s_sel     = (reset_n && m_valid && state != ERR) ? win : '0;
  assign sel_ready = |(s_sel & s_ready);
  assign m_ready   = sel_ready || state == ERR;
  assign m_rdata   = state == ERR ? ERR_DATA : (|s_sel ? win_rdata : 32'h0);
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: if (m_valid) begin
        state_nx = !hit ? ERR : (sel_ready ? IDLE : WAIT);
        cnt_nx = (hit && !sel_ready) ? CW'(1) : '0;
      end
      WAIT: if (!m_valid || sel_ready) begin
        state_nx = IDLE;
        cnt_nx = '0;
      end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
        state_nx = ERR;
        cnt_nx = '0;
      end else cnt_nx = cnt + 1'b1;
      default: begin
        state_nx = IDLE;
        cnt_nx = '0;
      end
    endcase
  end
  assign err_entry = state_nx == ERR && state != ERR;
  // a new error in the clear cycle restarts the status rather than being lost
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      err_irq <= 1'b0;
      err_addr <= '0;
      err_write <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (err_entry) begin
        err_irq <= 1'b1;
        err_count <= err_clr ? 8'd1 : (err_count == 8'hFF ? err_count : err_count + 8'd1);
        if (!err_irq || err_clr) begin
          err_addr <= m_addr;
          err_write <= |m_wstrb;
        end
      end else if (err_clr) begin
        err_irq <= 1'b0;
        err_addr <= '0;
        err_write <= 1'b0;
        err_count <= '0;
      end
    end
endmodule

// File: tb/tb_bus_interconnect.sv
// tb_bus_interconnect: directed scenarios checked every cycle against a
// transaction-age reference model, plus literal checkpoints.
module tb_bus_interconnect;
  localparam int NS = 3;
  localparam int TO = 8;
  localparam logic [NS*32-1:0] BASE = {32'h0002_0000, 32'h0001_0000, 32'h0003_0000};
  localparam logic [NS*32-1:0] MASK = {32'hFFFF_E000, 32'hFFFD_0000, 32'hFFFF_0000};
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic m_valid = 1'b0;
  logic [31:0] m_addr = '0;
  logic [3:0] m_wstrb = '0;
  logic m_ready;
  logic [31:0] m_rdata;
  logic [NS-1:0] s_sel;
  logic [NS-1:0] s_ready = '0;
  logic [NS*32-1:0] s_rdata;
  logic err_irq;
  logic [31:0] err_addr;
  logic err_write;
  logic [7:0] err_count;
  logic err_clr = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] mb [NS] = '{32'h0003_0000, 32'h0001_0000, 32'h0002_0000};
  logic [31:0] mm [NS] = '{32'hFFFF_0000, 32'hFFFD_0000, 32'hFFFF_E000};
  logic [31:0] sd [NS] = '{32'hA000_0000, 32'hB111_1111, 32'hC222_2222};
  int age = -1;
  bit err_next = 1'b0;
  bit e_irq = 1'b0;
  logic [31:0] e_addr = '0;
  bit e_write = 1'b0;
  int e_count = 0;
  assign s_rdata = {sd[2], sd[1], sd[0]};
  always #5 clk = ~clk;
  bus_interconnect #(
    .NUM_SLAVES(NS), .SLV_BASE(BASE), .SLV_MASK(MASK),
    .TIMEOUT_CYCLES(TO), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .m_valid(m_valid), .m_addr(m_addr),
    .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata), .s_sel(s_sel),
    .s_ready(s_ready), .s_rdata(s_rdata), .err_irq(err_irq), .err_addr(err_addr),
    .err_write(err_write), .err_count(err_count), .err_clr(err_clr)
  );
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & mm[i]) == mb[i]) return i;
    return -1;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic compare_model();
    logic r;
    logic [NS-1:0] sl;
    logic [31:0] rd;
    int idx;
    r = 1'b0;
    sl = '0;
    rd = '0;
    if (reset_n && err_next) begin
      r = 1'b1;
      rd = 32'hDEAD_BEEF;
    end else if (reset_n && m_valid) begin
      idx = decode(m_addr);
      if (idx >= 0) begin
        sl[idx] = 1'b1;
        r = s_ready[idx];
        rd = sd[idx];
      end
    end
    chk("model_m_ready", 32'(m_ready), 32'(r));
    chk("model_s_sel", 32'(s_sel), 32'(sl));
    chk("model_m_rdata", m_rdata, rd);
    chk("model_err_irq", 32'(err_irq), 32'(reset_n && e_irq));
    chk("model_err_addr", err_addr, reset_n ? e_addr : 32'h0);
    chk("model_err_write", 32'(err_write), 32'(reset_n && e_write));
    chk("model_err_count", 32'(err_count), reset_n ? 32'(e_count) : 32'h0);
  endtask
  task automatic update_model();
    int idx, cur;
    bit raise;
    raise = 1'b0;
    if (!reset_n) begin
      age = -1;
      err_next = 1'b0;
      e_irq = 1'b0;
      e_addr = '0;
      e_write = 1'b0;
      e_count = 0;
      return;
    end
    if (err_next) begin
      err_next = 1'b0;
      age = -1;
    end else if (m_valid) begin
      idx = decode(m_addr);
      cur = age < 0 ? 0 : age;
      if (idx < 0) raise = 1'b1;
      else if (s_ready[idx]) age = -1;
      else if (cur == TO) raise = 1'b1;
      else age = cur + 1;
    end else age = -1;
    if (raise) begin
      err_next = 1'b1;
      age = -1;
      if (!e_irq || err_clr) begin
        e_addr = m_addr;
        e_write = |m_wstrb;
      end
      e_count = err_clr ? 1 : (e_count < 255 ? e_count + 1 : 255);
      e_irq = 1'b1;
    end else if (err_clr) begin
      e_irq = 1'b0;
      e_addr = '0;
      e_write = 1'b0;
      e_count = 0;
    end
  endtask
  task automatic tick();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    update_model();
    #1;
  endtask
  initial begin
    m_valid = 1'b1;
    m_addr = 32'h0002_0010;
    s_ready = 3'b111;
    #1;
    chk("lit_rst_sel", 32'(s_sel), 32'h0);
    chk("lit_rst_ready", 32'(m_ready), 32'h0);
    chk("lit_rst_rdata", m_rdata, 32'h0);
    chk("lit_rst_count", 32'(err_count), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    m_valid = 1'b0;
    s_ready = '0;
    tick();
    s_ready = 3'b100;
    m_valid = 1'b1;
    m_addr = 32'h0002_0010;
    #1;
    chk("lit_zw_sel", 32'(s_sel), 32'h4);
    chk("lit_zw_ready", 32'(m_ready), 32'h1);
    chk("lit_zw_rdata", m_rdata, 32'hC222_2222);
    tick();
    m_addr = 32'h0003_0004;
    s_ready = 3'b011;
    #1;
    chk("lit_prio_sel", 32'(s_sel), 32'h1);
    chk("lit_prio_rdata", m_rdata, 32'hA000_0000);
    tick();
    m_addr = 32'h0001_0008;
    for (int c = 1; c <= 4; c++) begin
      s_ready = c == 4 ? 3'b010 : 3'b101;
      #1;
      chk("lit_ws_ready", 32'(m_ready), 32'(c == 4));
      chk("lit_ws_sel", 32'(s_sel), 32'h2);
      tick();
    end
    m_addr = 32'h0002_0010;
    s_ready = 3'b100;
    #1;
    chk("lit_b2b_ready", 32'(m_ready), 32'h1);
    tick();
    m_valid = 1'b0;
    tick();
    chk("lit_ws_count", 32'(err_count), 32'h0);
    chk("lit_ws_irq", 32'(err_irq), 32'h0);
    m_valid = 1'b1;
    m_addr = 32'h4000_0000;
    m_wstrb = 4'hF;
    s_ready = 3'b111;
    #1;
    chk("lit_um_ready0", 32'(m_ready), 32'h0);
    chk("lit_um_sel0", 32'(s_sel), 32'h0);
    tick();
    chk("lit_um_ready1", 32'(m_ready), 32'h1);
    chk("lit_um_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("lit_um_sel1", 32'(s_sel), 32'h0);
    chk("lit_um_irq", 32'(err_irq), 32'h1);
    chk("lit_um_addr", err_addr, 32'h4000_0000);
    chk("lit_um_write", 32'(err_write), 32'h1);
    chk("lit_um_count", 32'(err_count), 32'h1);
    m_valid = 1'b0;
    m_wstrb = '0;
    tick();
    chk("lit_um_done", 32'(m_ready), 32'h0);
    m_valid = 1'b1;
    m_addr = 32'h5000_0000;
    tick();
    m_valid = 1'b0;
    chk("lit_e2_count", 32'(err_count), 32'h2);
    chk("lit_e2_addr", err_addr, 32'h4000_0000);
    tick();
    m_addr = 32'h0002_0010;
    s_ready = 3'b011;
    m_valid = 1'b1;
    for (int c = 0; c <= TO; c++) begin
      #1;
      chk("lit_to_wait", 32'(m_ready), 32'h0);
      tick();
    end
    s_ready = 3'b111;
    #1;
    chk("lit_to_ready", 32'(m_ready), 32'h1);
    chk("lit_to_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("lit_to_sel", 32'(s_sel), 32'h0);
    chk("lit_to_count", 32'(err_count), 32'h3);
    m_valid = 1'b0;
    tick();
    m_valid = 1'b1;
    m_addr = 32'h6000_0000;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_valid = 1'b0;
    chk("lit_cc_irq", 32'(err_irq), 32'h1);
    chk("lit_cc_count", 32'(err_count), 32'h1);
    chk("lit_cc_addr", err_addr, 32'h6000_0000);
    chk("lit_cc_write", 32'(err_write), 32'h0);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("lit_clr_irq", 32'(err_irq), 32'h0);
    chk("lit_clr_count", 32'(err_count), 32'h0);
    chk("lit_clr_addr", err_addr, 32'h0);
    m_valid = 1'b1;
    m_addr = 32'h7000_0000;
    tick();
    m_valid = 1'b0;
    tick();
    m_addr = 32'h0002_0010;
    s_ready = '0;
    m_valid = 1'b1;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    s_ready = 3'b100;
    #1;
    chk("lit_rw_ready", 32'(m_ready), 32'h0);
    chk("lit_rw_sel", 32'(s_sel), 32'h0);
    chk("lit_rw_rdata", m_rdata, 32'h0);
    chk("lit_rw_irq", 32'(err_irq), 32'h0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("lit_rw_after_ready", 32'(m_ready), 32'h1);
    chk("lit_rw_after_sel", 32'(s_sel), 32'h4);
    tick();
    m_valid = 1'b0;
    tick();
    for (int n = 0; n < 256; n++) begin
      m_valid = 1'b1;
      m_addr = 32'h8000_0000;
      tick();
      m_valid = 1'b0;
      tick();
    end
    chk("lit_sat_count", 32'(err_count), 32'hFF);
    chk("lit_sat_addr", err_addr, 32'h8000_0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
